// File: rtl/exe_branch_flush_unit.sv
// exe_branch_flush_unit: EXE-stage branch target, flush/shadow FSM and NZCV status register; optional BRANCH_STATS_EN counters
module exe_branch_flush_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             B,
  input  logic             S,
  input  logic [31:0]      PC,
  input  logic [23:0]      Signed_imm_24,
  input  logic [3:0]       ALU_Status,
  output logic [3:0]       SR,
  output logic             Branch_taken,
  output logic [31:0]      Branch_Address,
  output logic             flush,
  output logic             in_shadow,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic {IDLE, SHADOW} state_t;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam bit HAS_SHADOW = FLUSH_CYCLES > 0;
  state_t state_q;
  logic [3:0] cnt_q;
  logic [3:0] sr_q;
  logic in_shadow_q;
  assign Branch_Address = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
  assign Branch_taken = ~rst & (state_q == IDLE) & B & ~freeze;
  assign flush = ~rst & ((state_q == SHADOW) | Branch_taken);
  assign SR = sr_q;
  assign in_shadow = in_shadow_q;
  // Shadow FSM and status register; wrong-path B/S are ignored while in SHADOW
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      in_shadow_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (S & ~freeze) sr_q <= ALU_Status;
      if (Branch_taken && HAS_SHADOW) begin
        state_q <= SHADOW;
        cnt_q <= CNT_INIT;
        in_shadow_q <= 1'b1;
      end
    end else if (!freeze) begin
      if (cnt_q == 4'd0) begin
        state_q <= IDLE;
        in_shadow_q <= 1'b0;
      end else cnt_q <= cnt_q - 4'd1;
    end
  end
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, fl_cnt_q;
  // Free-running statistics, wrapping at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      if (Branch_taken) br_cnt_q <= br_cnt_q + 1'b1;
      if (flush) fl_cnt_q <= fl_cnt_q + 1'b1;
    end
  end
  assign br_count = br_cnt_q;
  assign flush_count = fl_cnt_q;
`else
  assign br_count = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_exe_branch_flush_unit.sv
// tb_exe_branch_flush_unit: directed vector bench for exe_branch_flush_unit
module tb_exe_branch_flush_unit;
  logic clk = 1'b0, rst = 1'b1, freeze = 1'b0, B = 1'b0, S = 1'b0;
  logic [31:0] PC = '0;
  logic [23:0] imm = '0;
  logic [3:0] alu = '0;
  logic [3:0] sr;
  logic bt, fl, sh;
  logic [31:0] ba, brc, flc;
  logic frz2 = 1'b0, b2 = 1'b0, s2 = 1'b0;
  logic [31:0] pc2 = '0;
  logic [23:0] imm2 = '0;
  logic [3:0] alu2 = '0;
  logic [3:0] sr2;
  logic bt2, fl2, sh2;
  logic [31:0] ba2, brc2, flc2;
  int checks = 0, errors = 0;

  exe_branch_flush_unit #(.FLUSH_CYCLES(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .freeze(freeze), .B(B), .S(S), .PC(PC),
    .Signed_imm_24(imm), .ALU_Status(alu), .SR(sr), .Branch_taken(bt),
    .Branch_Address(ba), .flush(fl), .in_shadow(sh), .br_count(brc), .flush_count(flc)
  );

  exe_branch_flush_unit #(.FLUSH_CYCLES(2), .CNT_W(32)) u2 (
    .clk(clk), .rst(rst), .freeze(frz2), .B(b2), .S(s2), .PC(pc2),
    .Signed_imm_24(imm2), .ALU_Status(alu2), .SR(sr2), .Branch_taken(bt2),
    .Branch_Address(ba2), .flush(fl2), .in_shadow(sh2), .br_count(brc2), .flush_count(flc2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic frz, b, s;
    logic [31:0] pc;
    logic [23:0] imm;
    logic [3:0] alu;
    logic bt, fl, sh;
    logic [31:0] addr;
    logic [3:0] sr;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  initial begin
    v[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,        24'h0,      4'h5, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0};
    v[1]  = '{1'b0, 1'b1, 1'b0, 32'h100,      24'h4,      4'h0, 1'b1, 1'b1, 1'b0, 32'h110,      4'h5};
    v[2]  = '{1'b0, 1'b1, 1'b1, 32'h0,        24'h0,      4'hF, 1'b0, 1'b1, 1'b1, 32'h0,        4'h5};
    v[3]  = '{1'b0, 1'b1, 1'b0, 32'h8,        24'hFFFFFC, 4'h0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF8, 4'h5};
    v[4]  = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 24'h1,      4'h0, 1'b0, 1'b1, 1'b1, 32'h0,        4'h5};
    v[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        24'h0,      4'h0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h5};
    v[6]  = '{1'b1, 1'b1, 1'b1, 32'h0,        24'h0,      4'hA, 1'b0, 1'b0, 1'b0, 32'h0,        4'h5};
    v[7]  = '{1'b1, 1'b1, 1'b1, 32'h0,        24'h0,      4'hA, 1'b0, 1'b0, 1'b0, 32'h0,        4'h5};
    v[8]  = '{1'b0, 1'b1, 1'b1, 32'h100,      24'h0,      4'hA, 1'b1, 1'b1, 1'b0, 32'h100,      4'h5};
    v[9]  = '{1'b1, 1'b0, 1'b1, 32'h0,        24'h0,      4'hF, 1'b0, 1'b1, 1'b1, 32'h0,        4'hA};
    v[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        24'h0,      4'h0, 1'b0, 1'b1, 1'b1, 32'h0,        4'hA};
    v[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        24'h0,      4'h0, 1'b0, 1'b1, 1'b1, 32'h0,        4'hA};
    v[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        24'h0,      4'h0, 1'b0, 1'b0, 1'b0, 32'h0,        4'hA};
    v[13] = '{1'b0, 1'b0, 1'b1, 32'h0,        24'h0,      4'h3, 1'b0, 1'b0, 1'b0, 32'h0,        4'hA};
    v[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        24'h0,      4'h0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h3};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_sr", 32'(sr), 32'h0);
    chk("reset_flush", 32'(fl), 32'h0);
    chk("reset_shadow", 32'(sh), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      freeze = v[i].frz; B = v[i].b; S = v[i].s; PC = v[i].pc; imm = v[i].imm; alu = v[i].alu;
      #1;
      chk($sformatf("v%0d_taken", i), 32'(bt), 32'(v[i].bt));
      chk($sformatf("v%0d_flush", i), 32'(fl), 32'(v[i].fl));
      chk($sformatf("v%0d_shadow", i), 32'(sh), 32'(v[i].sh));
      chk($sformatf("v%0d_addr", i), ba, v[i].addr);
      chk($sformatf("v%0d_sr", i), 32'(sr), 32'(v[i].sr));
    end
    @(negedge clk);
    freeze = 1'b0; B = 1'b0; S = 1'b0;
`ifdef BRANCH_STATS_EN
    chk("u1_br_count", brc, 32'd3);
    chk("u1_flush_count", flc, 32'd8);
`else
    chk("u1_br_count", brc, 32'd0);
    chk("u1_flush_count", flc, 32'd0);
`endif
    // reset in the middle of a shadow window, checked between clock edges
    @(negedge clk);
    B = 1'b1; S = 1'b1; alu = 4'h7;
    @(negedge clk);
    chk("pre_rst_flush", 32'(fl), 32'h1);
    chk("pre_rst_shadow", 32'(sh), 32'h1);
    chk("pre_rst_sr", 32'(sr), 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flush", 32'(fl), 32'h0);
    chk("async_rst_shadow", 32'(sh), 32'h0);
    chk("async_rst_sr", 32'(sr), 32'h0);
    chk("async_rst_taken", 32'(bt), 32'h0);
    chk("async_rst_brc", brc, 32'h0);
    @(negedge clk);
    rst = 1'b0; B = 1'b0; S = 1'b0;
    // FLUSH_CYCLES=2: three branches, each flushing three cycles, wrong-path B ignored
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b2 = 1'b1;
      #1;
      chk($sformatf("u2_b%0d_taken", k), 32'(bt2), 32'h1);
      chk($sformatf("u2_b%0d_flush0", k), 32'(fl2), 32'h1);
      @(negedge clk);
      #1;
      chk($sformatf("u2_b%0d_squash", k), 32'(bt2), 32'h0);
      chk($sformatf("u2_b%0d_flush1", k), 32'(fl2), 32'h1);
      chk($sformatf("u2_b%0d_shadow1", k), 32'(sh2), 32'h1);
      @(negedge clk);
      b2 = 1'b0;
      #1;
      chk($sformatf("u2_b%0d_flush2", k), 32'(fl2), 32'h1);
      chk($sformatf("u2_b%0d_shadow2", k), 32'(sh2), 32'h1);
      @(negedge clk);
      #1;
      chk($sformatf("u2_b%0d_flush3", k), 32'(fl2), 32'h0);
      chk($sformatf("u2_b%0d_shadow3", k), 32'(sh2), 32'h0);
    end
`ifdef BRANCH_STATS_EN
    chk("u2_br_count", brc2, 32'd3);
    chk("u2_flush_count", flc2, 32'd9);
`else
    chk("u2_br_count", brc2, 32'd0);
    chk("u2_flush_count", flc2, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
